// File: rtl/prot_trig_seq_if.sv
// prot_trig_seq_if
//   Bus between the trigger sequencer, its configuration source, the serial
//   byte receiver, the data_comp comparator and the capture controller.
//   master : drives configuration, control and byte strobes; sees results.
//   slave  : the sequencer itself.
//   Signals:
//     cfg_we/cfg_idx/cfg_match/cfg_mask - table write port (IDLE only)
//     seq_len_m1, timeout               - sequence length-1, idle timeout
//     arm, clr                          - start/restart, abort
//     serial_vld, prot_trig             - byte strobe, data_comp result
//     match, mask                       - current stage pair to data_comp
//     armed, stage, triggered, trig_pulse - status
interface prot_trig_seq_if #(
    parameter int DEPTH = 4,
    parameter int TMO_W = 16
);
    localparam int IW = $clog2(DEPTH);

    logic             cfg_we;
    logic [IW-1:0]    cfg_idx;
    logic [7:0]       cfg_match;
    logic [7:0]       cfg_mask;
    logic [IW-1:0]    seq_len_m1;
    logic [TMO_W-1:0] timeout;
    logic             arm;
    logic             clr;
    logic             serial_vld;
    logic             prot_trig;
    logic [7:0]       match;
    logic [7:0]       mask;
    logic             armed;
    logic [IW-1:0]    stage;
    logic             triggered;
    logic             trig_pulse;

    modport master (
        output cfg_we, cfg_idx, cfg_match, cfg_mask, seq_len_m1, timeout,
               arm, clr, serial_vld, prot_trig,
        input  match, mask, armed, stage, triggered, trig_pulse
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_match, cfg_mask, seq_len_m1, timeout,
               arm, clr, serial_vld, prot_trig,
        output match, mask, armed, stage, triggered, trig_pulse
    );
endinterface

// File: rtl/prot_trig_seq.sv
// prot_trig_seq
//   Multi-stage protocol trigger sequencer. Holds DEPTH match/mask pairs,
//   presents table[stage] to the external byte comparator, advances one
//   stage per matching byte and triggers after seq_len_m1+1 consecutive
//   in-order matches. An idle gap of `timeout` cycles mid-sequence drops the
//   sequence back to stage 0.
//   Ports:
//     clk  - system clock
//     rst  - asynchronous active-high reset (also clears the table)
//     bus  - prot_trig_seq_if.slave (configuration, control, byte, status)
module prot_trig_seq #(
    parameter int DEPTH = 4,
    parameter int TMO_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    prot_trig_seq_if.slave    bus
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
    localparam logic [IW-1:0]    STG_ONE = IW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_TRIG  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           stage_q, stage_d;
    logic [IW-1:0]           len_q, len_d;
    logic [TMO_W-1:0]        timer_q, timer_d;
    logic                    pulse_q, pulse_d;
    logic [DEPTH-1:0][7:0]   tbl_match_q, tbl_match_d;
    logic [DEPTH-1:0][7:0]   tbl_mask_q, tbl_mask_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stage_q     <= '0;
            len_q       <= '0;
            timer_q     <= '0;
            pulse_q     <= 1'b0;
            tbl_match_q <= '0;
            tbl_mask_q  <= '1;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            len_q       <= len_d;
            timer_q     <= timer_d;
            pulse_q     <= pulse_d;
            tbl_match_q <= tbl_match_d;
            tbl_mask_q  <= tbl_mask_d;
        end
    end

    // Next state
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        len_d       = len_q;
        timer_d     = timer_q;
        pulse_d     = 1'b0;
        tbl_match_d = tbl_match_q;
        tbl_mask_d  = tbl_mask_q;

        // Table is frozen once a sequence is running.
        if (state_q == S_IDLE && bus.cfg_we) begin
            tbl_match_d[bus.cfg_idx] = bus.cfg_match;
            tbl_mask_d[bus.cfg_idx]  = bus.cfg_mask;
        end

        if (bus.clr) begin
            state_d = S_IDLE;
            stage_d = '0;
            timer_d = '0;
        end else if (bus.arm) begin
            // A byte arriving with arm is deliberately dropped.
            state_d = S_ARMED;
            stage_d = '0;
            timer_d = '0;
            len_d   = bus.seq_len_m1;
        end else if (state_q == S_ARMED) begin
            if (bus.serial_vld) begin
                if (bus.prot_trig) begin
                    if (stage_q == len_q) begin
                        state_d = S_TRIG;
                        pulse_d = 1'b1;
                    end else begin
                        stage_d = stage_q + STG_ONE;
                        timer_d = '0;
                    end
                end else begin
                    // Mismatch restarts; this byte is not retried at stage 0.
                    stage_d = '0;
                    timer_d = '0;
                end
            end else if (stage_q != '0) begin
                // timer counts completed idle cycles, so comparing against
                // timeout-1 expires after exactly `timeout` idle cycles.
                if (bus.timeout != '0 && timer_q == bus.timeout - TMO_ONE) begin
                    stage_d = '0;
                    timer_d = '0;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TMO_ONE;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        bus.match      = tbl_match_q[stage_q];
        bus.mask       = tbl_mask_q[stage_q];
        bus.stage      = stage_q;
        bus.armed      = (state_q == S_ARMED);
        bus.triggered  = (state_q == S_TRIG);
        bus.trig_pulse = pulse_q;
    end
endmodule

// File: doc/prot_trig_seq.md
Name: prot_trig_seq

Overview:
- Multi-stage protocol trigger sequencer for the logic-analyzer trigger path.
- Holds a table of up to DEPTH match/mask pairs and drives the current pair onto the downstream byte comparator (data_comp).
- Steps through the table on each matching received byte. Raises the trigger when SEQ_LEN consecutive bytes match in order.
- Sits between the UART/SPI byte receiver, the data_comp comparator and the capture controller.

Parameters:
- DEPTH, 4, number of match/mask stages. Power of 2, ≥2.
- TMO_W, 16, width of the inter-byte timeout counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cfg_we  in  1  write one table entry.
- cfg_idx  in  log2(DEPTH)  table entry to write.
- cfg_match  in  8  match value to write.
- cfg_mask  in  8  mask value to write; 1 = don't care.
- seq_len_m1  in  log2(DEPTH)  number of stages minus 1. Sampled at arm.
- timeout  in  TMO_W  max idle cycles between bytes once stage>0. 0 = disabled.
- arm  in  1  start or restart the sequence.
- clr  in  1  abort and return to IDLE.
- serial_vld  in  1  one-cycle strobe: serial byte received.
- prot_trig  in  1  data_comp result for the current byte. Combinational, same cycle.
- match  out  8  to data_comp: table[stage].match.
- mask  out  8  to data_comp: table[stage].mask.
- armed  out  1  high in ARMED.
- stage  out  log2(DEPTH)  current stage index.
- triggered  out  1  high in TRIGGERED.
- trig_pulse  out  1  one-cycle pulse on entry to TRIGGERED.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - State IDLE; stage=0; timer=0; len register=0.
  - All table entries match=8'h00, mask=8'hFF, so match=8'h00 and mask=8'hFF out of reset.
  - armed=0, triggered=0, trig_pulse=0.
- match/mask are a combinational mux of table[stage], where both the table and stage are registered.
  - A stage change is visible on match/mask the cycle after the accepting edge.
- Table writes are accepted only in IDLE and take effect at the clock edge. cfg_we is ignored in ARMED and TRIGGERED.
- States: IDLE, ARMED, TRIGGERED.
- Priority, highest first: clr, arm, byte event, timeout.
  - clr in any state -> IDLE, stage=0, timer=0.
  - arm in any state, without clr -> ARMED, stage=0, timer=0, len=seq_len_m1. A byte in that same cycle is ignored.
- ARMED, serial_vld=1, prot_trig=1:
  - If stage==len: -> TRIGGERED, trig_pulse=1 for one cycle, stage holds.
  - Otherwise stage+1, timer=0.
- ARMED, serial_vld=1, prot_trig=0:
  - stage=0, timer=0.
  - The failing byte is not re-evaluated against stage 0.
- ARMED with stage>0, no byte:
  - timer increments each cycle.
  - When timeout!=0 and timer==timeout-1: stage=0, timer=0. The stage is therefore reset after exactly timeout idle cycles.
  - A byte in the expiry cycle takes priority over the timeout.
- ARMED with stage==0: timer holds at 0.
- len=0 means a single-byte trigger.
- TRIGGERED: holds until clr or arm; bytes are ignored.
- serial_vld with prot_trig=X outside ARMED must not affect state.
- Timer saturates and never wraps. With timeout=0, stage never auto-resets.
- Reset mid-sequence: immediate return to reset values, asynchronously. The table is cleared.

Test Plan:
1. Reset, then read outputs -> match=00, mask=FF, stage=0, armed=0, triggered=0. Then cfg_we idx0 = (AB, 10) in IDLE -> next cycle match=AB, mask=10.
2. Load stages 0..2 = (AA,00), (55,00), (0F,F0); seq_len_m1=2; arm; bench models data_comp; send bytes AA, 55, 3F -> stage 0→1→2, trig_pulse high one cycle after the 3F edge, triggered stays 1.
3. Same table; send AA, 12, 55 -> the mismatch on 12 sets stage=0, then 55 fails stage 0 -> no trigger. Then send AA, 55, 0F -> trigger.
4. timeout=5; send AA, then idle 5 cycles -> stage returns to 0 at exactly cycle 5. With timeout=0, idle 1000 cycles -> stage stays 1.
5. While ARMED, cfg_we to idx1 with (99,00) -> table is unchanged (match still 55 at stage 1). clr asserted together with arm -> IDLE. While TRIGGERED, arm -> ARMED, stage=0, triggered=0.
6. rst asserted mid-sequence at stage=2 -> outputs go to reset values without a clock edge, and the table reads back (00, FF).
